ifetch_unit: RTL and testbench

- Multicycle fetch stage directly upstream of the main controller FSM.
- On a fetch request it reads the instruction at PC from instruction memory through a ready/valid handshake that tolerates wait states.
- It latches the word into the instruction register, advances PC by 4 and presents decoded fields (opcode, funct, shamt, rs, rt, rd, imm) to the controller.
- It accepts PC overrides (branch/jump) from the controller's datapath.

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/ifetch_unit_if.sv | 13 +
 rtl/ifetch_decode.sv | 20 ++
 rtl/ifetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_ifetch_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM encoding, instruction field positions, opcodes.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } ifetch_state_t;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    // Decoded view of one instruction word; imm overlaps rd/shamt/funct.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory read port: address + read strobe out, data + ready back.
// Latency: none (wires only).
// Backpressure: slave stalls the master by holding mem_ready low; master holds mem_rd/mem_addr.
// master: fetch unit side (drives mem_addr, mem_rd). slave: memory side.
interface ifetch_unit_if;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (output mem_addr, output mem_rd, input mem_rdata, input mem_ready);
    modport slave  (input mem_addr, input mem_rd, output mem_rdata, output mem_ready);
endinterface

// File: rtl/ifetch_decode.sv
// Pure combinational slicer of an instruction word into its MIPS fields.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: ir in (32), fields out (instr_fields_t).
module ifetch_decode
    import mips_pkg::*;
(
    input  logic [31:0]   ir,
    output instr_fields_t fields
);

    assign fields.opcode = ir[OPC_HI:OPC_LO];
    assign fields.rs     = ir[RS_HI:RS_LO];
    assign fields.rt     = ir[RT_HI:RT_LO];
    assign fields.rd     = ir[RD_HI:RD_LO];
    assign fields.shamt  = ir[SHAMT_HI:SHAMT_LO];
    assign fields.funct  = ir[FUNCT_HI:FUNCT_LO];
    assign fields.imm    = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/ifetch_unit.sv
// Multicycle instruction fetch: reads mem at PC into IR, advances PC, exposes decoded fields.
// Latency: fetch_req to instr_valid is 2 cycles with zero wait states, +1 per wait state.
// Backpressure: memory stalls via mem_ready (up to MAX_WAIT wait cycles, then bus_fault); requests outside IDLE are dropped.
// Ports: clk, reset_n (async active-low); fetch_req, pc_load, pc_next from controller;
//        mem (ifetch_unit_if.master); instr_valid, busy, bus_fault, pc, ir, decoded fields out.
// Optional: IFETCH_ALIGN_CHECK_EN adds a misaligned-PC check and the sticky misalign output.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         fetch_req,
    input  logic         pc_load,
    input  logic [31:0]  pc_next,
    ifetch_unit_if.master mem,
    output logic         instr_valid,
    output logic         busy,
    output logic         bus_fault,
    output logic [31:0]  pc,
    output logic [31:0]  ir,
    output logic [5:0]   opcode,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   rd,
    output logic [4:0]   shamt,
    output logic [5:0]   funct,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic         misalign,
`endif
    output logic [15:0]  imm
);

    localparam int             WCW        = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    ifetch_state_t  state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    ir_q, ir_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic           mem_rd_q, mem_rd_d;
    logic           instr_valid_q, instr_valid_d;
    logic           bus_fault_q, bus_fault_d;
    logic           fetch_ok;
    logic           accept;
    logic           capture;
    logic           timeout;
    instr_fields_t  fields;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic align_fault;
    // A misaligned PC never reaches the bus; the request is turned into a fault.
    assign fetch_ok    = fetch_req & ~(|pc_q[1:0]);
    assign align_fault = (state_q == ST_IDLE) & fetch_req & (|pc_q[1:0]);
`else
    assign fetch_ok    = fetch_req;
`endif

    assign accept  = (state_q == ST_IDLE) & fetch_ok;
    assign capture = ((state_q == ST_REQ) | (state_q == ST_WAIT)) & mem.mem_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (fetch_ok) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (mem.mem_ready) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            ST_WAIT: begin
                if (mem.mem_ready) begin
                    state_d    = ST_DONE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                    timeout    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        // A controller override always wins, including over the post-fetch increment.
        if (pc_load)                 pc_d = pc_next;
        else if (state_q == ST_DONE) pc_d = pc_q + PC_STEP;
        else                         pc_d = pc_q;

        ir_d = capture ? mem.mem_rdata : ir_q;

        // Address tracks PC while idle so the request edge captures the pre-override PC.
        if (state_q == ST_IDLE) begin
`ifdef IFETCH_ALIGN_CHECK_EN
            mem_addr_d = pc_q;
`else
            mem_addr_d = {pc_q[31:2], 2'b00};
`endif
        end else begin
            mem_addr_d = mem_addr_q;
        end

        mem_rd_d      = (state_d == ST_REQ) | (state_d == ST_WAIT);
        instr_valid_d = (state_d == ST_DONE);

        bus_fault_d = bus_fault_q;
        if (accept)  bus_fault_d = 1'b0;
        if (timeout) bus_fault_d = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
        if (accept) misalign_d = 1'b0;
        if (align_fault) begin
            bus_fault_d = 1'b1;
            misalign_d  = 1'b1;
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            mem_addr_q    <= RESET_PC;
            mem_rd_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            bus_fault_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            instr_valid_q <= instr_valid_d;
            bus_fault_q   <= bus_fault_d;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) misalign_q <= 1'b0;
        else          misalign_q <= misalign_d;
    end
    assign misalign = misalign_q;
`endif

    ifetch_decode u_decode (
        .ir     (ir_q),
        .fields (fields)
    );

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = mem_rd_q;
    assign instr_valid  = instr_valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign bus_fault    = bus_fault_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign opcode       = fields.opcode;
    assign rs           = fields.rs;
    assign rt           = fields.rt;
    assign rd           = fields.rd;
    assign shamt        = fields.shamt;
    assign funct        = fields.funct;
    assign imm          = fields.imm;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: table of fetch vectors plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: the bench models memory wait states by delaying mem_ready.
module tb_ifetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset_n, fetch_req, pc_load;
    logic [31:0] pc_next;
    logic        instr_valid, busy, bus_fault;
    logic [31:0] pc, ir;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    ifetch_unit_if bus();

    ifetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .mem         (bus),
        .instr_valid (instr_valid),
        .busy        (busy),
        .bus_fault   (bus_fault),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
`ifdef IFETCH_ALIGN_CHECK_EN
        .misalign    (misalign),
`endif
        .imm         (imm)
    );

    typedef struct {
        logic [31:0] data;
        int          delay;
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
    } vec_t;

    vec_t        vec[6];
    vec_t        exp_q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, valid_cnt = 0, valid_cyc = 0;
    int          rd_cycles = 0, addr_bad = 0, strobes = 0, rsp_delay = 0;
    logic [31:0] rsp_data = '0, exp_pc = '0, exp_addr = '0, last_ir = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: observe just after the edge, play the memory, score completed fetches.
    task automatic step();
        vec_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_rd) begin
            rd_cycles++;
            if (bus.mem_addr !== exp_addr) addr_bad++;
            if (strobes == rsp_delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rsp_data;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
            strobes++;
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
            strobes = 0;
        end
        if (instr_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_instr_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ir",     ir,             e.data);
                chk("sb_opcode", {26'd0, opcode}, {26'd0, e.opc});
                chk("sb_rs",     {27'd0, rs},     {27'd0, e.rs});
                chk("sb_rt",     {27'd0, rt},     {27'd0, e.rt});
                chk("sb_rd",     {27'd0, rd},     {27'd0, e.rd});
                chk("sb_shamt",  {27'd0, shamt},  {27'd0, e.sh});
                chk("sb_funct",  {26'd0, funct},  {26'd0, e.fn});
                chk("sb_imm",    {16'd0, imm},    {16'd0, e.imm});
            end
        end
    endtask

    task automatic run_fetch(input vec_t v, input int delay, input bit ld,
                             input logic [31:0] ld_val, input bit pulse, input string tag);
        int v0, r0, a0, k, n;
        rsp_data = v.data;
        rsp_delay = delay;
        exp_q.push_back(v);
        exp_addr = exp_pc;
        v0 = valid_cnt; r0 = rd_cycles; a0 = addr_bad; k = cyc;
        fetch_req = 1'b1;
        pc_load   = ld;
        pc_next   = ld_val;
        step();
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        if (ld) exp_pc = ld_val;
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
        chk($sformatf("%s_fault_clr", tag), {31'd0, bus_fault}, 32'd0);
        n = 0;
        while (busy && n < 40) begin
            if (pulse && n == 1) fetch_req = 1'b1;
            step();
            fetch_req = 1'b0;
            n++;
        end
        if (n >= 40) chk($sformatf("%s_hang", tag), {31'd0, busy}, 32'd0);
        if (pulse) begin
            step();
            step();
            chk($sformatf("%s_no_requeue", tag), {31'd0, busy}, 32'd0);
        end
        exp_pc = exp_pc + 32'd4;
        last_ir = v.data;
        chk($sformatf("%s_latency", tag), valid_cyc - k, 2 + delay);
        chk($sformatf("%s_rd_cycles", tag), rd_cycles - r0, delay + 1);
        chk($sformatf("%s_addr", tag), addr_bad - a0, 0);
        chk($sformatf("%s_valid_once", tag), valid_cnt - v0, 1);
        chk($sformatf("%s_pc", tag), pc, exp_pc);
        chk($sformatf("%s_sb_empty", tag), exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int v0, r0, a0, n;
        //            data          dly opc    rs     rt     rd     sh     fn     imm
        vec[0] = '{32'h2008_0005, 0, 6'd8,  5'd0,  5'd8,  5'd0,  5'd0,  6'd5,  16'h0005};
        vec[1] = '{32'h0109_5016, 3, 6'd0,  5'd8,  5'd9,  5'd10, 5'd0,  6'd22, 16'h5016};
        vec[2] = '{32'hFFFF_FFFF, 1, 6'd63, 5'd31, 5'd31, 5'd31, 5'd31, 6'd63, 16'hFFFF};
        vec[3] = '{32'h8C43_0010, 2, 6'd35, 5'd2,  5'd3,  5'd0,  5'd0,  6'd16, 16'h0010};
        vec[4] = '{32'h0000_0000, 0, 6'd0,  5'd0,  5'd0,  5'd0,  5'd0,  6'd0,  16'h0000};
        vec[5] = '{32'h0000_07C0, 0, 6'd0,  5'd0,  5'd0,  5'd0,  5'd31, 6'd0,  16'h07C0};

        reset_n = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_next = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus_fault", {31'd0, bus_fault}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++)
            run_fetch(vec[i], vec[i].delay, 1'b0, 32'h0, 1'b0, $sformatf("vec%0d", i));

        // Timeout: memory never answers.
        rsp_delay = -1;
        exp_addr = exp_pc;
        v0 = valid_cnt; r0 = rd_cycles; a0 = addr_bad;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("tmo_bus_fault", {31'd0, bus_fault}, 32'd1);
        chk("tmo_pc", pc, exp_pc);
        chk("tmo_ir", ir, last_ir);
        chk("tmo_no_valid", valid_cnt - v0, 0);
        chk("tmo_rd_cycles", rd_cycles - r0, MAX_WAIT + 1);
        chk("tmo_addr", addr_bad - a0, 0);
        run_fetch(vec[2], 1, 1'b0, 32'h0, 1'b0, "post_fault");

        // Branch override in the DONE cycle beats the increment.
        rsp_data = vec[0].data;
        rsp_delay = 0;
        exp_q.push_back(vec[0]);
        exp_addr = exp_pc;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 0;
        while (!instr_valid && n < 10) begin step(); n++; end
        chk("br_done_seen", {31'd0, instr_valid}, 32'd1);
        pc_load = 1'b1;
        pc_next = 32'h0000_0100;
        step();
        pc_load = 1'b0;
        exp_pc = 32'h0000_0100;
        chk("br_pc", pc, 32'h0000_0100);
        run_fetch(vec[1], 0, 1'b0, 32'h0, 1'b0, "br_target");

        // Wrap at the top of the address space, with a request pulsed mid-wait.
        pc_load = 1'b1;
        pc_next = 32'hFFFF_FFFC;
        step();
        pc_load = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        chk("wrap_load_pc", pc, 32'hFFFF_FFFC);
        run_fetch(vec[3], 3, 1'b0, 32'h0, 1'b1, "wrap");
        chk("wrap_pc_zero", pc, 32'h0);

        // Load and request together in IDLE: fetch from old pc, pc takes the target.
        run_fetch(vec[5], 1, 1'b1, 32'h0000_0200, 1'b0, "idle_load");

        // Reset in the middle of a wait.
        rsp_delay = -1;
        exp_addr = exp_pc;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        step();
        chk("mid_rst_pre_rd", {31'd0, bus.mem_rd}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("mid_rst_ir", ir, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        exp_pc = 32'h0;
        v0 = valid_cnt;
        step();
        step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("mid_rst_no_valid", valid_cnt - v0, 0);
        chk("mid_rst_idle", {31'd0, busy}, 32'd0);
        run_fetch(vec[0], 0, 1'b0, 32'h0, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
